pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have one clock, CLK; reset is synchronous and active-low, Resetn.
REQ-002 SHALL have port CLK  in  1  pipeline clock; all state updates on negedge CLK, same edge as the pipeline registers.
REQ-003 SHALL have port Resetn  in  1  synchronous active-low reset.
REQ-004 SHALL have ports id_rs, id_rt  in  5 each  ID-stage source register numbers; id_uses_rt  in  1  instruction reads rt.
REQ-005 SHALL have ports ex_rs, ex_rt  in  5 each  EX-stage source register numbers (forwarding).
REQ-006 SHALL have ports ex_rd  in  5, ex_regwr  in  1, ex_memtoreg  in  1  EX-stage destination, write enable and load flag.
REQ-007 SHALL have ports mem_rd  in  5, mem_regwr  in  1  MEM-stage destination and write enable (EX/M register outputs).
REQ-008 SHALL have ports wb_rd  in  5, wb_regwr  in  1  WB-stage destination and write enable.
REQ-009 SHALL have ports m_branch, m_zero, m_jump  in  1 each  MEM-stage Branch, zero and Jump.
REQ-010 SHALL have ports mem_access  in  1  MEM-stage load/store; dmem_ready  in  1  data memory completes this cycle.
REQ-011 SHALL have ports pc_en, ifid_en, idex_en, exm_en  out  1 each  register load enables.
REQ-012 SHALL have ports ifid_flush, idex_flush, exm_flush  out  1 each  force bubble (all control fields zero) on next load.
REQ-013 SHALL have ports fwd_a, fwd_b  out  2 each  ALU operand select: 00 register file, 10 EX/M ALUout, 01 WB data.
REQ-014 SHALL have port state  out  2  current FSM state (debug).

Function
REQ-015 SHALL implement FSM states RUN=00, LU_STALL=01, MEM_WAIT=10; 11 unreachable, decodes as RUN.
REQ-016 SHALL define freeze = mem_access & ~dmem_ready; redirect = (m_branch & m_zero) | m_jump; loaduse = ex_memtoreg & ex_regwr & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
REQ-017 SHALL, by default, drive all enables 1 and all flushes 0 (combinational from state and inputs).
REQ-018 SHALL give freeze highest priority in every state: all four enables 0, all flushes 0, next state MEM_WAIT.
REQ-019 SHALL, in MEM_WAIT, leave on the first cycle with dmem_ready=1: enables 1 that cycle, next state RUN; redirect/loaduse evaluated that cycle per REQ-020/021.
REQ-020 SHALL, on redirect without freeze: pc_en=1, ifid_flush=idex_flush=exm_flush=1, next state RUN; redirect overrides loaduse.
REQ-021 SHALL, on loaduse in RUN without freeze/redirect: pc_en=0, ifid_en=0, idex_flush=1, next state LU_STALL.
REQ-022 SHALL, in LU_STALL, not re-evaluate loaduse (load now in MEM, covered by forwarding), enables 1, next state RUN; exactly one bubble per load-use.
REQ-023 SHALL compute fwd_a: 10 if mem_regwr & mem_rd!=0 & mem_rd==ex_rs; else 01 if wb_regwr & wb_rd!=0 & wb_rd==ex_rs; else 00; fwd_b identically on ex_rt.
REQ-024 SHALL keep forwarding purely combinational, independent of state and freeze.
REQ-025 SHALL never forward or stall on register 0.

Reset
REQ-026 SHALL, while Resetn=0 at negedge CLK, set state=RUN (and stall_cnt=0 if present) regardless of other inputs.
REQ-027 SHALL, during reset, drive enables 1, flushes 1, fwd_a=fwd_b=00, so pipeline registers load bubbles.
REQ-028 SHALL abandon MEM_WAIT or LU_STALL immediately on reset mid-operation; no pending stall survives.

Configuration
REQ-029 SHALL, when HAZARD_PERF_CNT_EN is defined, add output stall_cnt  out  16  counting cycles with pc_en=0, saturating at 16'hFFFF, zeroed on reset.
REQ-030 SHALL, without HAZARD_PERF_CNT_EN, omit stall_cnt port and counter; all other behaviour identical.

Verification
REQ-031 SHALL cover: ex load to rd=5, id_rs=5 -> one cycle pc_en=0, ifid_en=0, idex_flush=1, state 01, then RUN, fwd_a=10 next cycle.
REQ-032 SHALL cover: m_branch=1, m_zero=1 with loaduse also true -> three flushes 1, pc_en=1, state stays 00.
REQ-033 SHALL cover: mem_access=1, dmem_ready=0 for 3 cycles then 1 -> enables 0 for 3 cycles, state 10, return to 00; stall_cnt=3 with macro.
REQ-034 SHALL cover: mem_rd=wb_rd=7, both regwr, ex_rs=7 -> fwd_a=10; mem_rd=0 variant -> fwd_a=01; rd=0 both -> 00.
REQ-035 SHALL cover: Resetn=0 asserted while in MEM_WAIT -> state 00 at next negedge, flushes 1, stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard control: load-use stall, redirect flush, memory freeze, forwarding
// Optional stall-cycle counter enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl (
  input  logic       CLK,
  input  logic       Resetn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwr,
  input  logic       ex_memtoreg,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwr,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwr,
  input  logic       m_branch,
  input  logic       m_zero,
  input  logic       m_jump,
  input  logic       mem_access,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exm_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exm_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10,
    SPARE    = 2'b11
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  logic freeze;
  logic redirect;
  logic loaduse;

  assign freeze   = mem_access & ~dmem_ready;
  assign redirect = (m_branch & m_zero) | m_jump;
  assign loaduse  = ex_memtoreg & ex_regwr & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  assign state = cur_state;

  always_ff @(negedge CLK) begin
    if (!Resetn)
      cur_state <= RUN;
    else
      cur_state <= nxt_state;
  end

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exm_en     = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exm_flush  = 1'b0;
    nxt_state  = RUN;
    if (!Resetn) begin
      // Registers keep loading so the whole pipeline fills with bubbles.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exm_flush  = 1'b1;
    end else if (freeze) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exm_en    = 1'b0;
      nxt_state = MEM_WAIT;
    end else if (redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exm_flush  = 1'b1;
    end else if (cur_state != LU_STALL && loaduse) begin
      // The load has reached MEM once LU_STALL is left, so one bubble suffices.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      nxt_state  = LU_STALL;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (Resetn) begin
      if (mem_regwr && mem_rd != 5'd0 && mem_rd == ex_rs)
        fwd_a = 2'b10;
      else if (wb_regwr && wb_rd != 5'd0 && wb_rd == ex_rs)
        fwd_a = 2'b01;
      if (mem_regwr && mem_rd != 5'd0 && mem_rd == ex_rt)
        fwd_b = 2'b10;
      else if (wb_regwr && wb_rd != 5'd0 && wb_rd == ex_rt)
        fwd_b = 2'b01;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(negedge CLK) begin
    if (!Resetn)
      stall_cnt <= 16'd0;
    else if (!pc_en && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       CLK;
  logic       Resetn;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rt, ex_regwr, ex_memtoreg, mem_regwr, wb_regwr;
  logic       m_branch, m_zero, m_jump, mem_access, dmem_ready;
  logic       pc_en, ifid_en, idex_en, exm_en;
  logic       ifid_flush, idex_flush, exm_flush;
  logic [1:0] fwd_a, fwd_b, state;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  pipe_hazard_ctrl dut (
    .CLK(CLK), .Resetn(Resetn),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwr(ex_regwr), .ex_memtoreg(ex_memtoreg),
    .mem_rd(mem_rd), .mem_regwr(mem_regwr),
    .wb_rd(wb_rd), .wb_regwr(wb_regwr),
    .m_branch(m_branch), .m_zero(m_zero), .m_jump(m_jump),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exm_en(exm_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exm_flush(exm_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  logic [3:0] en_vec;
  logic [2:0] fl_vec;
  assign en_vec = {pc_en, ifid_en, idex_en, exm_en};
  assign fl_vec = {ifid_flush, idex_flush, exm_flush};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwr = 0; ex_memtoreg = 0;
    mem_rd = 0; mem_regwr = 0; wb_rd = 0; wb_regwr = 0;
    m_branch = 0; m_zero = 0; m_jump = 0;
    mem_access = 0; dmem_ready = 1;
  endtask

  // Inputs change 1 ns after posedge, well away from the active negedge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic ex_load(input logic [4:0] rd);
    ex_memtoreg = 1; ex_regwr = 1; ex_rd = rd;
  endtask

  initial begin
    Resetn = 0;
    idle();
    mem_access = 1; dmem_ready = 0;
    mem_rd = 7; mem_regwr = 1; ex_rs = 7;
    #2;
    check("rst_en",    16'(en_vec), 16'hF);
    check("rst_flush", 16'(fl_vec), 16'h7);
    check("rst_fwd_a", 16'(fwd_a),  16'h0);
    cyc();
    check("rst_state", 16'(state), 16'h0);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_cnt", stall_cnt, 16'h0);
`endif
    Resetn = 1; idle(); #1;
    check("idle_en",    16'(en_vec), 16'hF);
    check("idle_flush", 16'(fl_vec), 16'h0);
    check("idle_state", 16'(state),  16'h0);

    // memory freeze: three stalled cycles, then completion
    cyc(); mem_access = 1; dmem_ready = 0; #1;
    check("fz1_en",    16'(en_vec), 16'h0);
    check("fz1_flush", 16'(fl_vec), 16'h0);
    cyc(); m_jump = 1; #1;
    check("fz2_state", 16'(state),  16'h2);
    check("fz2_en",    16'(en_vec), 16'h0);
    check("fz2_flush", 16'(fl_vec), 16'h0);
    cyc(); m_jump = 0; #1;
    check("fz3_state", 16'(state),  16'h2);
    check("fz3_en",    16'(en_vec), 16'h0);
    cyc(); dmem_ready = 1; #1;
    check("fz4_state", 16'(state),  16'h2);
    check("fz4_en",    16'(en_vec), 16'hF);
    cyc(); idle(); #1;
    check("fz_exit_state", 16'(state), 16'h0);
`ifdef HAZARD_PERF_CNT_EN
    check("fz_cnt", stall_cnt, 16'd3);
`endif

    // load-use on rs, load inputs held during LU_STALL
    cyc(); ex_load(5); id_rs = 5; #1;
    check("lu_en",    16'(en_vec), 16'h3);
    check("lu_flush", 16'(fl_vec), 16'h2);
    cyc(); mem_rd = 5; mem_regwr = 1; ex_rs = 5; #1;
    check("lus_state", 16'(state),  16'h1);
    check("lus_en",    16'(en_vec), 16'hF);
    check("lus_flush", 16'(fl_vec), 16'h0);
    check("lus_fwd_a", 16'(fwd_a),  16'h2);
    cyc(); idle(); #1;
    check("lu_exit_state", 16'(state), 16'h0);

    // load-use on rt gated by id_uses_rt, and r0
    cyc(); ex_load(9); id_rt = 9; id_rs = 3; #1;
    check("lu_rt_unused_en", 16'(en_vec), 16'hF);
    cyc(); id_uses_rt = 1; #1;
    check("lu_rt_en", 16'(en_vec), 16'h3);
    cyc(); idle(); #1;
    check("lu_rt_state", 16'(state), 16'h1);
    cyc(); ex_load(0); id_rs = 0; #1;
    check("lu_r0_en",    16'(en_vec), 16'hF);
    check("lu_r0_state", 16'(state),  16'h0);

    // redirect overrides load-use
    cyc(); idle(); ex_load(5); id_rs = 5; m_branch = 1; m_zero = 1; #1;
    check("br_en",    16'(en_vec), 16'hF);
    check("br_flush", 16'(fl_vec), 16'h7);
    cyc(); idle(); #1;
    check("br_state", 16'(state), 16'h0);
    cyc(); m_branch = 1; m_zero = 0; #1;
    check("br_nt_flush", 16'(fl_vec), 16'h0);
    cyc(); idle(); m_jump = 1; #1;
    check("jmp_flush", 16'(fl_vec), 16'h7);

    // forwarding
    cyc(); idle(); mem_rd = 7; wb_rd = 7; mem_regwr = 1; wb_regwr = 1; ex_rs = 7; #1;
    check("fwd_mem", 16'(fwd_a), 16'h2);
    cyc(); mem_rd = 0; #1;
    check("fwd_wb", 16'(fwd_a), 16'h1);
    cyc(); wb_rd = 0; ex_rs = 0; #1;
    check("fwd_r0", 16'(fwd_a), 16'h0);
    cyc(); mem_rd = 7; mem_regwr = 0; wb_rd = 7; ex_rt = 7; #1;
    check("fwd_b_wb", 16'(fwd_b), 16'h1);
    cyc(); mem_regwr = 1; ex_rs = 7; mem_access = 1; dmem_ready = 0; #1;
    check("fwd_frz_a", 16'(fwd_a), 16'h2);
    check("fwd_frz_b", 16'(fwd_b), 16'h2);

    // reset while in MEM_WAIT
    cyc(); #0;
    check("mw_state", 16'(state), 16'h2);
    Resetn = 0; #1;
    check("mw_rst_en",    16'(en_vec), 16'hF);
    check("mw_rst_flush", 16'(fl_vec), 16'h7);
    cyc();
    check("mw_rst_state", 16'(state), 16'h0);
`ifdef HAZARD_PERF_CNT_EN
    check("mw_rst_cnt", stall_cnt, 16'h0);
`endif
    Resetn = 1; idle();
    cyc();
    check("post_rst_state", 16'(state),  16'h0);
    check("post_rst_en",    16'(en_vec), 16'hF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
